// File: rtl/hazard_info_pipe.sv
// Register-use/write information pipeline (D -> E -> M -> W) feeding the
// forwarding/stall unit. Stall bubbles E and holds D; M and W always advance.
// A saturating counter records stalled cycles for performance debug.
module hazard_info_pipe #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned TNEW_W = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic [REG_W-1:0]  A1D,
    input  logic [REG_W-1:0]  A2D,
    input  logic [REG_W-1:0]  A3D,
    input  logic              WED,
    input  logic [TNEW_W-1:0] TnewD,
    output logic [REG_W-1:0]  A1E,
    output logic [REG_W-1:0]  A2E,
    output logic [REG_W-1:0]  A1M,
    output logic [REG_W-1:0]  A2M,
    output logic [REG_W-1:0]  A3E,
    output logic [REG_W-1:0]  A3M,
    output logic [REG_W-1:0]  A3W,
    output logic              WEE,
    output logic              WEM,
    output logic              WEW,
    output logic [TNEW_W-1:0] TnewE,
    output logic [TNEW_W-1:0] TnewM,
    output logic [CNT_W-1:0]  StallCnt
);

    logic              we_norm;
    logic [TNEW_W-1:0] tnew_m_next;
    logic [CNT_W-1:0]  cnt_next;

    // Capture normalisation, Tnew countdown and saturating stall count
    always_comb begin
        // Register 0 is never a real destination, so never advertise it as a write
        we_norm     = WED & (A3D != '0);
        tnew_m_next = (TnewE == '0) ? '0 : TnewE - TNEW_W'(1);
        cnt_next    = StallCnt;
        if (Stall && (StallCnt != {CNT_W{1'b1}})) begin
            cnt_next = StallCnt + CNT_W'(1);
        end
    end

    // E stage: capture from D, or take a bubble while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            A1E   <= '0;
            A2E   <= '0;
            A3E   <= '0;
            WEE   <= 1'b0;
            TnewE <= '0;
        end else if (Stall) begin
            A1E   <= '0;
            A2E   <= '0;
            A3E   <= '0;
            WEE   <= 1'b0;
            TnewE <= '0;
        end else begin
            A1E   <= A1D;
            A2E   <= A2D;
            A3E   <= A3D;
            WEE   <= we_norm;
            TnewE <= TnewD;
        end
    end

    // M and W stages: advance every cycle regardless of Stall
    always_ff @(posedge clk) begin
        if (!reset) begin
            A1M   <= '0;
            A2M   <= '0;
            A3M   <= '0;
            WEM   <= 1'b0;
            TnewM <= '0;
            A3W   <= '0;
            WEW   <= 1'b0;
        end else begin
            A1M   <= A1E;
            A2M   <= A2E;
            A3M   <= A3E;
            WEM   <= WEE;
            TnewM <= tnew_m_next;
            A3W   <= A3M;
            WEW   <= WEM;
        end
    end

    // Stall-cycle counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            StallCnt <= '0;
        end else begin
            StallCnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_hazard_info_pipe.sv
// Scoreboard bench: the driver updates a history-based model at each edge and
// queues the expected outputs; a monitor compares on the falling edge.
module tb_hazard_info_pipe;

    logic       clk = 1'b0;
    logic       reset, Stall, WED;
    logic [4:0] A1D, A2D, A3D;
    logic [2:0] TnewD;

    logic [4:0]  A1E, A2E, A1M, A2M, A3E, A3M, A3W;
    logic        WEE, WEM, WEW;
    logic [2:0]  TnewE, TnewM;
    logic [15:0] StallCnt;

    logic [4:0] s_A1E, s_A2E, s_A1M, s_A2M, s_A3E, s_A3M, s_A3W;
    logic       s_WEE, s_WEM, s_WEW;
    logic [2:0] s_TnewE, s_TnewM;
    logic [1:0] s_StallCnt;

    always #5 clk = ~clk;

    hazard_info_pipe dut (
        .clk(clk), .reset(reset), .Stall(Stall),
        .A1D(A1D), .A2D(A2D), .A3D(A3D), .WED(WED), .TnewD(TnewD),
        .A1E(A1E), .A2E(A2E), .A1M(A1M), .A2M(A2M),
        .A3E(A3E), .A3M(A3M), .A3W(A3W),
        .WEE(WEE), .WEM(WEM), .WEW(WEW),
        .TnewE(TnewE), .TnewM(TnewM), .StallCnt(StallCnt)
    );

    hazard_info_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .Stall(Stall),
        .A1D(A1D), .A2D(A2D), .A3D(A3D), .WED(WED), .TnewD(TnewD),
        .A1E(s_A1E), .A2E(s_A2E), .A1M(s_A1M), .A2M(s_A2M),
        .A3E(s_A3E), .A3M(s_A3M), .A3W(s_A3W),
        .WEE(s_WEE), .WEM(s_WEM), .WEW(s_WEW),
        .TnewE(s_TnewE), .TnewM(s_TnewM), .StallCnt(s_StallCnt)
    );

    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        logic       we;
        logic [2:0] tnew;
    } ent_t;

    typedef struct {
        ent_t e;
        ent_t m;
        ent_t w;
        int   cnt;
        int   cnt_sat;
    } snap_t;

    // Model: hist holds the entries that entered E on the last three edges,
    // oldest first; M and W are simply older entries of that history.
    ent_t  hist[$];
    int    m_cnt, m_cnt_sat;
    snap_t exp_q[$];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    task automatic step(input logic r, input logic st, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3,
                        input logic we, input logic [2:0] tn);
        ent_t  n;
        snap_t s;
        reset = r; Stall = st; A1D = a1; A2D = a2; A3D = a3; WED = we; TnewD = tn;
        @(posedge clk);
        if (!r) begin
            hist = '{ent_t'(0), ent_t'(0), ent_t'(0)};
            m_cnt = 0;
            m_cnt_sat = 0;
        end else begin
            n = '0;
            if (!st) begin
                n.a1 = a1; n.a2 = a2; n.a3 = a3;
                n.we = we && (a3 != 0);
                n.tnew = tn;
            end
            hist.push_back(n);
            void'(hist.pop_front());
            if (st) begin
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_cnt_sat = (m_cnt_sat < 3) ? m_cnt_sat + 1 : 3;
            end
        end
        s.e = hist[2];
        s.m = hist[1];
        s.m.tnew = (hist[1].tnew == 0) ? 3'd0 : hist[1].tnew - 3'd1;
        s.w = hist[0];
        s.cnt = m_cnt;
        s.cnt_sat = m_cnt_sat;
        exp_q.push_back(s);
        @(negedge clk);
    endtask

    // Monitor: compare every queued expectation against both instances
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t s;
            s = exp_q.pop_front();
            chk("A1E", int'(A1E), int'(s.e.a1));
            chk("A2E", int'(A2E), int'(s.e.a2));
            chk("A3E", int'(A3E), int'(s.e.a3));
            chk("WEE", int'(WEE), int'(s.e.we));
            chk("TnewE", int'(TnewE), int'(s.e.tnew));
            chk("A1M", int'(A1M), int'(s.m.a1));
            chk("A2M", int'(A2M), int'(s.m.a2));
            chk("A3M", int'(A3M), int'(s.m.a3));
            chk("WEM", int'(WEM), int'(s.m.we));
            chk("TnewM", int'(TnewM), int'(s.m.tnew));
            chk("A3W", int'(A3W), int'(s.w.a3));
            chk("WEW", int'(WEW), int'(s.w.we));
            chk("StallCnt", int'(StallCnt), s.cnt);
            chk("sat_A3M", int'(s_A3M), int'(s.m.a3));
            chk("sat_TnewM", int'(s_TnewM), int'(s.m.tnew));
            chk("sat_StallCnt", int'(s_StallCnt), s.cnt_sat);
        end
    end

    initial begin
        hist = '{ent_t'(0), ent_t'(0), ent_t'(0)};
        m_cnt = 0;
        m_cnt_sat = 0;
        // Reset held two cycles with nonzero D inputs
        step(0, 0, 5'd7, 5'd9, 5'd11, 1, 3'd2);
        step(0, 1, 5'd7, 5'd9, 5'd11, 1, 3'd2);
        // Plain flow of a load-like entry
        step(1, 0, 5'd3, 5'd4, 5'd8, 1, 3'd2);
        // Zero destination is never a write
        step(1, 0, 5'd1, 5'd2, 5'd0, 1, 3'd1);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 3'd0);
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 3'd0);
        // Load in E, dependent held in D for one stall cycle
        step(1, 0, 5'd2, 5'd6, 5'd5, 1, 3'd2);
        step(1, 1, 5'd5, 5'd1, 5'd9, 1, 3'd1);
        step(1, 0, 5'd5, 5'd1, 5'd9, 1, 3'd1);
        // Three back-to-back stalls, then the held entry enters E
        step(1, 1, 5'd12, 5'd13, 5'd14, 1, 3'd7);
        step(1, 1, 5'd12, 5'd13, 5'd14, 1, 3'd7);
        step(1, 1, 5'd12, 5'd13, 5'd14, 1, 3'd7);
        step(1, 0, 5'd12, 5'd13, 5'd14, 1, 3'd7);
        // Enough further stalls to saturate the narrow counter
        for (int i = 0; i < 5; i++) step(1, 1, 5'd1, 5'd1, 5'd1, 1, 3'd1);
        step(1, 0, 5'd20, 5'd21, 5'd22, 1, 3'd3);
        step(1, 0, 5'd23, 5'd24, 5'd25, 1, 3'd4);
        step(1, 0, 5'd26, 5'd27, 5'd28, 1, 3'd5);
        // Reset mid-stream with live entries in E/M/W, and with Stall asserted
        step(0, 1, 5'd30, 5'd31, 5'd29, 1, 3'd6);
        step(1, 0, 5'd30, 5'd31, 5'd29, 1, 3'd6);
        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a3;
            a3 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
                 5'($urandom), 5'($urandom), a3, 1'($urandom), 3'($urandom));
        end
        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_info_pipe.md
Name: hazard_info_pipe

Overview:
- Producer side of the pipeline hazard/forwarding interface in the 5-stage MIPS core (D/E/M/W).
- Carries each instruction's register-use and register-write information (source/destination addresses, write enable, Tnew) from D through E, M and W.
- Presents the per-stage values (A1E, A2E, A2M, A3E/M/W, WEE/M/W, TnewE/M) that the forwarding/stall unit consumes.
- Consumes that unit's Stall output: bubbles E and holds D; M and W keep advancing. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_W, 5, register address width
TNEW_W, 3, Tnew field width
CNT_W, 16, stall counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous reset, active-low (0 = reset)
Stall  input  1  from forwarding/stall unit; 1 = hold D, insert bubble into E
A1D  input  REG_W  rs address of instruction in D
A2D  input  REG_W  rt address of instruction in D
A3D  input  REG_W  destination address of instruction in D
WED  input  1  instruction in D writes the register file
TnewD  input  TNEW_W  cycles after entering E until result is ready (0 none/jal-style, 1 ALU, 2 load)
A1E  output  REG_W  rs address in E
A2E  output  REG_W  rt address in E
A1M  output  REG_W  rs address in M
A2M  output  REG_W  rt address in M
A3E  output  REG_W  destination in E
A3M  output  REG_W  destination in M
A3W  output  REG_W  destination in W
WEE  output  1  write enable in E
WEM  output  1  write enable in M
WEW  output  1  write enable in W
TnewE  output  TNEW_W  remaining Tnew in E
TnewM  output  TNEW_W  remaining Tnew in M
StallCnt  output  CNT_W  cycles with Stall=1 since reset, saturating

Behaviour:
- Reset: every output register cleared to 0 on the first rising edge with reset=0. Reset overrides Stall. Reset mid-stream discards all in-flight entries.
- Capture normalisation: effective write enable = WED & (A3D != 0). A3D=0 is never advertised as a write.
- Each edge with reset=1 and Stall=0:
  - E <= {A1D, A2D, A3D, normalised WED, TnewD}.
  - M <= {A1E, A2E, A3E, WEE, TnewM_next}, where TnewM_next = (TnewE==0) ? 0 : TnewE-1. Saturating; never wraps.
  - W <= {A3M, WEM}.
- Each edge with reset=1 and Stall=1:
  - E <= bubble: A1E=A2E=A3E=0, WEE=0, TnewE=0.
  - M and W advance exactly as in the no-stall case.
  - D inputs are ignored this cycle; upstream holds them stable.
- Latency: one cycle per stage. D info appears on the E outputs one edge after capture, M after two, W after three.
- Back-to-back stalls: each stalled cycle inserts another bubble. The held D instruction enters E on the first edge with Stall=0.
- Consecutive writers to the same register are tracked independently per stage, with no merging. The consumer's M-over-W priority resolves them.
- StallCnt:
  - Increments by 1 on each edge with reset=1 and Stall=1.
  - Holds at 2^CNT_W-1 once reached.
  - Cleared only by reset.
- No combinational path from any input to any output; all outputs are registered.
- TnewD values above 2 are legal and decrement normally; TnewM = TnewE-1.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with nonzero D inputs -> all outputs 0, StallCnt=0. Release reset -> first capture appears on E after one edge.
2. Flow: capture A1D=3, A2D=4, A3D=8, WED=1, TnewD=2 with Stall=0 -> next cycle A3E=8, WEE=1, TnewE=2. Following cycle A3M=8, WEM=1, TnewM=1, A2M=4. Next cycle A3W=8, WEW=1.
3. Zero destination: A3D=0, WED=1 -> WEE=0, and WEM and WEW are 0 as the entry flows through.
4. Stall bubble: load (A3D=5, TnewD=2) in E, then Stall=1 for one cycle with a dependent instruction (A1D=5) in D -> E becomes 0/0/0, M shows A3M=5, TnewM=1, StallCnt=1. After Stall drops, the dependent instruction appears with A1E=5.
5. Multi-stall: Stall=1 for 3 consecutive cycles -> 3 bubbles flow through E/M/W, StallCnt=3, D entry enters E on cycle 4.
6. Saturation and reset mid-stream: CNT_W=2, 5 stall cycles -> StallCnt sticks at 3. Then reset=0 with valid entries in E/M/W -> all cleared next edge.
